// File: rtl/shift_seq_ctrl_if.sv
// Handshake and serial-stream bundle between a parallel word source and shift_seq_ctrl.
// The master drives start/din/hold; the slave (sequencer) returns status and the serial bit.
interface shift_seq_ctrl_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 4
);
  logic          start;
  logic [W-1:0]  din;
  logic          hold;
  logic          ready;
  logic          sout;
  logic          sout_en;
  logic          done;
  logic [CW-1:0] bit_cnt;

  modport master (
    output start, din, hold,
    input  ready, sout, sout_en, done, bit_cnt
  );

  modport slave (
    input  start, din, hold,
    output ready, sout, sout_en, done, bit_cnt
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial sequencer: latches a word on start and emits it one bit per clock,
// with a pause input, a done pulse and a registered bit counter.
module shift_seq_ctrl #(
  parameter int unsigned W         = 8,
  parameter int unsigned CW        = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  shift_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic          sout_q, sout_d;
  logic          sout_en_q, sout_en_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The bit to send next always sits at the outgoing end of the shadow register.
  logic next_bit;
  assign next_bit = MSB_FIRST ? shadow_q[W-1] : shadow_q[0];

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    sout_d    = sout_q;
    sout_en_d = 1'b0;
    done_d    = 1'b0;
    ready_d   = ready_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sout_d    = MSB_FIRST ? bus.din[W-1] : bus.din[0];
          shadow_d  = MSB_FIRST ? (bus.din << 1) : (bus.din >> 1);
          sout_en_d = 1'b1;
          cnt_d     = CW'(1);
          ready_d   = 1'b0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (!bus.hold) begin
          if (cnt_q == CW'(W)) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            sout_d    = next_bit;
            shadow_d  = MSB_FIRST ? (shadow_q << 1) : (shadow_q >> 1);
            sout_en_d = 1'b1;
            cnt_d     = cnt_q + CW'(1);
          end
        end
      end
      StDone: begin
        ready_d = 1'b1;
        cnt_d   = '0;
        sout_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      sout_q    <= 1'b0;
      sout_en_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      sout_q    <= sout_d;
      sout_en_q <= sout_en_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.sout    = sout_q;
  assign bus.sout_en = sout_en_q;
  assign bus.done    = done_q;
  assign bus.bit_cnt = cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: LSB-first and MSB-first instances driven in lockstep and checked
// against a per-word timeline built from the bit/hold/done timing rules.
module tb_shift_seq_ctrl;
  localparam int unsigned W    = 8;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = 64;

  typedef int hv_t [W];

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.W(W), .CW(CW)) if_l ();
  shift_seq_ctrl_if #(.W(W), .CW(CW)) if_m ();

  shift_seq_ctrl #(.W(W), .CW(CW), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (if_l.slave)
  );

  shift_seq_ctrl #(.W(W), .CW(CW), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (if_m.slave)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [W-1:0] d, input logic h);
    if_l.start = s;
    if_l.din   = d;
    if_l.hold  = h;
    if_m.start = s;
    if_m.din   = d;
    if_m.hold  = h;
  endtask

  task automatic check_all(input string ph, input logic el, input logic em, input logic en,
                           input logic dn, input logic rdy, input int cnt);
    chk({ph, "/sout_l"},    16'(if_l.sout),    16'(el));
    chk({ph, "/sout_m"},    16'(if_m.sout),    16'(em));
    chk({ph, "/sout_en_l"}, 16'(if_l.sout_en), 16'(en));
    chk({ph, "/sout_en_m"}, 16'(if_m.sout_en), 16'(en));
    chk({ph, "/done_l"},    16'(if_l.done),    16'(dn));
    chk({ph, "/done_m"},    16'(if_m.done),    16'(dn));
    chk({ph, "/ready_l"},   16'(if_l.ready),   16'(rdy));
    chk({ph, "/ready_m"},   16'(if_m.ready),   16'(rdy));
    chk({ph, "/cnt_l"},     16'(if_l.bit_cnt), 16'(cnt));
    chk({ph, "/cnt_m"},     16'(if_m.bit_cnt), 16'(cnt));
  endtask

  task automatic chk_reset(input string ph);
    check_all(ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  // Called in an idle cycle; returns in the cycle where ready is back high.
  // noise: 0 = start low, 1 = random start pulses, 2 = start held high throughout.
  task automatic run_word(input logic [W-1:0] d, input hv_t h, input int noise,
                          input string tag);
    int   bidx [MAXC];
    logic en   [MAXC];
    logic dn   [MAXC];
    logic rdy  [MAXC];
    logic hd   [MAXC];
    int   cnt  [MAXC];
    int   c;
    int   last;
    logic s;
    logic el;
    logic em;
    for (int k = 0; k < MAXC; k++) begin
      bidx[k] = -1; en[k] = 1'b0; dn[k] = 1'b0; rdy[k] = 1'b0; hd[k] = 1'b0; cnt[k] = 0;
    end
    // Cycle 1 is the cycle after the accepting edge; each hold edge inserts one stalled cycle.
    c = 1;
    for (int i = 0; i < int'(W); i++) begin
      bidx[c] = i; en[c] = 1'b1; cnt[c] = i + 1; c++;
      for (int j = 0; j < h[i]; j++) begin
        hd[c-1] = 1'b1; bidx[c] = i; cnt[c] = i + 1; c++;
      end
    end
    bidx[c] = int'(W) - 1; dn[c] = 1'b1; cnt[c] = int'(W); c++;
    rdy[c] = 1'b1;
    last   = c;

    drive(1'b1, d, 1'($urandom_range(0, 1)));
    @(posedge clk); #1;
    for (c = 1; c <= last; c++) begin
      if (c < last) begin
        s = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive(s, W'($urandom), hd[c]);
      end else begin
        drive(noise == 2, W'($urandom), 1'b0);
      end
      el = (bidx[c] < 0) ? 1'b0 : d[bidx[c]];
      em = (bidx[c] < 0) ? 1'b0 : d[int'(W) - 1 - bidx[c]];
      check_all($sformatf("%s/c%0d", tag, c), el, em, en[c], dn[c], rdy[c], cnt[c]);
      if (c < last) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    hv_t z;
    hv_t hh;
    z = '{default: 0};

    // Reset held for two edges with start high: nothing may begin.
    rst = 1'b1;
    drive(1'b1, 8'hA5, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_reset("reset");
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk_reset("post_reset");

    run_word(8'h35, z, 0, "lsb_msb_35");

    hh    = z;
    hh[2] = 3;
    run_word(8'h35, hh, 0, "hold3");

    run_word(8'h35, z, 1, "start_noise");

    run_word(8'h35, z, 2, "b2b_a");
    run_word(8'hC6, z, 2, "b2b_b");
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk_reset("idle_after_b2b");

    // Reset after 4 bits: word discarded, no done afterwards.
    drive(1'b1, 8'h35, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 8'hFF, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst/cnt4", 16'(if_l.bit_cnt), 16'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset("midrst/rst");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_reset($sformatf("midrst/idle%0d", k));
    end
    run_word(8'h05, z, 0, "after_rst_05");

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < int'(W); i++) begin
        hh[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      run_word(W'($urandom), hh, int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk_reset("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
